// File: rtl/data_io_upload.sv
// data_io_upload: SPI-slave upload channel on SPI_SS2 that streams a core-filled FIFO to the MCU.
// SPI pins are oversampled in clk_sys; MOSI is sampled on detected SCK rises, MISO shifts on detected falls.
module data_io_upload #(
    parameter int         FIFO_AW    = 4,
    parameter logic [7:0] CMD_STATUS = 8'h55,
    parameter logic [7:0] CMD_READ   = 8'h56
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             spi_sck,
    input  logic             spi_ss,
    input  logic             spi_di,
    output logic             spi_do,
    output logic             spi_do_oe,
    input  logic             upload_req,
    input  logic [7:0]       wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [FIFO_AW:0] fifo_level,
    output logic             underrun,
    output logic [23:0]      bytes_sent
);
    typedef enum logic [2:0] {IDLE, CMD, STATUS, READ, IGNORE} state_t;
    state_t state, state_nx;
    logic [2:0] sck_q, ss_q;
    logic [1:0] di_q;
    logic sck_rise, sck_fall, ss_rise, ss_fall, di_r;
    logic [2:0] bit_cnt, bit_nx;
    logic [7:0] shift_in, sin_nx, shift_out, sout_nx, opcode, status;
    logic oe_nx, load_pend, pend_nx, und_nx, pop, push, req_q, last_rise;
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [7:0] mem [2**FIFO_AW];

    assign push     = wr_valid & wr_ready;
    assign wr_ready = ~fifo_level[FIFO_AW];
    assign spi_do   = spi_do_oe & shift_out[7];
    assign status   = {5'b0, underrun, fifo_level != '0, upload_req};

    // ss pipeline resets low so a select held low across reset never looks like a fresh fall
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sck_q <= '0;
            ss_q  <= '0;
            di_q  <= '0;
            {sck_rise, sck_fall, ss_rise, ss_fall, di_r} <= '0;
        end else begin
            sck_q    <= {sck_q[1:0], spi_sck};
            ss_q     <= {ss_q[1:0], spi_ss};
            di_q     <= {di_q[0], spi_di};
            sck_rise <= sck_q[1] & ~sck_q[2];
            sck_fall <= ~sck_q[1] & sck_q[2];
            ss_rise  <= ss_q[1] & ~ss_q[2];
            ss_fall  <= ~ss_q[1] & ss_q[2];
            di_r     <= di_q[1];
        end
    end

    always_comb begin
        state_nx  = state;
        bit_nx    = bit_cnt;
        sin_nx    = shift_in;
        sout_nx   = shift_out;
        oe_nx     = spi_do_oe;
        pend_nx   = load_pend;
        und_nx    = underrun;
        pop       = 1'b0;
        opcode    = {shift_in[6:0], di_r};
        last_rise = sck_rise && bit_cnt == 3'd7;
        if (sck_rise) begin
            bit_nx = bit_cnt + 3'd1;
            sin_nx = opcode;
        end
        case (state)
            IDLE: if (ss_fall) begin
                state_nx = CMD;
                bit_nx   = '0;
            end
            CMD: if (last_rise) begin
                state_nx = opcode == CMD_STATUS ? STATUS : opcode == CMD_READ ? READ : IGNORE;
                pend_nx  = 1'b1;
            end
            // status is loaded once; rotating makes the same byte repeat every 8 bits
            STATUS: if (sck_fall) begin
                sout_nx = load_pend ? status : {shift_out[6:0], shift_out[7]};
                und_nx  = load_pend ? 1'b0 : underrun;
                oe_nx   = 1'b1;
                pend_nx = 1'b0;
            end
            READ: begin
                if (last_rise) pend_nx = 1'b1;
                if (sck_fall && load_pend) begin
                    pop     = fifo_level != '0;
                    sout_nx = pop ? mem[rd_ptr] : 8'h00;
                    und_nx  = underrun | ~pop;
                    oe_nx   = 1'b1;
                    pend_nx = 1'b0;
                end else if (sck_fall) begin
                    sout_nx = {shift_out[6:0], 1'b0};
                end
            end
            default: ;
        endcase
        if (state != IDLE && ss_rise) begin
            state_nx = IDLE;
            oe_nx    = 1'b0;
            pend_nx  = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift_in  <= '0;
            shift_out <= '0;
            spi_do_oe <= 1'b0;
            load_pend <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            state     <= state_nx;
            bit_cnt   <= bit_nx;
            shift_in  <= sin_nx;
            shift_out <= sout_nx;
            spi_do_oe <= oe_nx;
            load_pend <= pend_nx;
            underrun  <= und_nx;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            req_q      <= 1'b0;
            bytes_sent <= '0;
        end else begin
            wr_ptr     <= wr_ptr + FIFO_AW'(push);
            rd_ptr     <= rd_ptr + FIFO_AW'(pop);
            fifo_level <= fifo_level + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
            req_q      <= upload_req;
            bytes_sent <= (upload_req & ~req_q) ? 24'd0 : bytes_sent + 24'(pop);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: tb/tb_data_io_upload.sv
// tb_data_io_upload: randomized SPI upload traffic checked against a queue-based model of the channel.
module tb_data_io_upload;
    localparam int HALF = 5;
    localparam logic [7:0] ST = 8'h55;
    localparam logic [7:0] RD = 8'h56;

    logic clk = 0, reset_n = 0, spi_sck = 0, spi_ss = 1, spi_di = 0;
    logic upload_req = 0, wr_valid = 0;
    logic [7:0] wr_data = 0;
    logic spi_do, spi_do_oe, wr_ready, underrun;
    logic [4:0] fifo_level;
    logic [23:0] bytes_sent;

    int vectors = 0, miscompares = 0;
    logic [7:0] q[$];
    logic m_und = 0;
    logic [23:0] m_sent = 0;

    data_io_upload dut (
        .clk_sys(clk), .reset_n(reset_n), .spi_sck(spi_sck), .spi_ss(spi_ss), .spi_di(spi_di),
        .spi_do(spi_do), .spi_do_oe(spi_do_oe), .upload_req(upload_req), .wr_data(wr_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .fifo_level(fifo_level), .underrun(underrun),
        .bytes_sent(bytes_sent)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        @(negedge clk);
        wr_data  = d;
        wr_valid = 1;
        if (q.size() < 16) q.push_back(d);
        @(negedge clk);
        wr_valid = 0;
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx,
                            output logic oa, output logic oo);
        rx = '0;
        oa = 1'b1;
        oo = 1'b0;
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            spi_di = tx[7-i];
            repeat (HALF) @(negedge clk);
            rx = {rx[6:0], spi_do};
            oa &= spi_do_oe;
            oo |= spi_do_oe;
            spi_sck = 1;
            repeat (HALF) @(negedge clk);
            spi_sck = 0;
        end
    endtask

    task automatic check_state();
        check("fifo_level", fifo_level, q.size());
        check("wr_ready", wr_ready, q.size() < 16);
        check("underrun", underrun, m_und);
        check("bytes_sent", bytes_sent, m_sent);
    endtask

    // one select-framed transfer: command, n full bytes, then extra loose bits
    task automatic xfer(input logic [7:0] cmd, input int n, input int extra);
        logic [7:0] rx, stat;
        logic oa, oo, active;
        logic [7:0] exp[$];
        active = cmd == ST || cmd == RD;
        spi_ss = 0;
        repeat (6) @(negedge clk);
        spi_bits(cmd, 8, rx, oa, oo);
        check("oe_cmd", oo, 0);
        stat = {5'b0, m_und, q.size() != 0, upload_req};
        if (cmd == RD) begin
            for (int i = 0; i <= n; i++) begin
                if (q.size() != 0) begin
                    exp.push_back(q.pop_front());
                    m_sent++;
                end else begin
                    exp.push_back(8'h00);
                    m_und = 1;
                end
            end
        end else if (cmd == ST) begin
            m_und = 0;
            for (int i = 0; i < n; i++) exp.push_back(stat);
        end
        for (int i = 0; i < n; i++) begin
            spi_bits(8'($urandom), 8, rx, oa, oo);
            if (active) begin
                check("miso", rx, exp[i]);
                check("oe_data", oa, 1);
            end else check("oe_ignore", oo, 0);
        end
        if (extra > 0) spi_bits(8'($urandom), extra, rx, oa, oo);
        repeat (2) @(negedge clk);
        spi_ss = 1;
        repeat (4) @(negedge clk);
        check("oe_ss_rise", spi_do_oe, 0);
        repeat (6) @(negedge clk);
        check_state();
    endtask

    task automatic toggle_req();
        @(negedge clk);
        upload_req = 0;
        repeat (3) @(negedge clk);
        upload_req = 1;
        @(negedge clk);
        m_sent = 0;
        check("sent_clear", bytes_sent, 0);
    endtask

    initial begin
        logic [7:0] rx, op;
        logic oa, oo;
        int np, k;
        repeat (3) @(negedge clk);
        check("rst_do", spi_do, 0);
        check("rst_oe", spi_do_oe, 0);
        check_state();
        reset_n = 1;
        repeat (8) @(negedge clk);
        upload_req = 1;
        repeat (2) @(negedge clk);

        push(8'hA5);
        push(8'h3C);
        check("fifo_level", fifo_level, 2);
        xfer(RD, 2, 0);
        xfer(RD, 1, 0);
        xfer(ST, 1, 0);

        for (int i = 0; i <= 16; i++) begin
            push(8'(i));
            if (i == 15) check("wr_ready_full", wr_ready, 0);
        end
        check("level_full", fifo_level, 16);
        xfer(RD, 16, 0);

        push(8'($urandom));
        push(8'($urandom));
        op = 8'h12;
        xfer(op, 2, 0);

        for (int i = 0; i < 3; i++) push(8'($urandom));
        xfer(RD, 0, 4);
        xfer(RD, 1, 0);
        toggle_req();

        for (int it = 0; it < 12; it++) begin
            np = $urandom_range(0, 6);
            for (int j = 0; j < np; j++) push(8'($urandom));
            if ($urandom_range(0, 3) == 0) toggle_req();
            k = $urandom_range(0, 3);
            op = 8'($urandom);
            if (op == ST || op == RD) op = 8'h00;
            xfer(k == 0 ? ST : k == 1 ? op : RD, $urandom_range(0, 4), 0);
        end

        for (int i = 0; i < 3; i++) push(8'($urandom));
        spi_ss = 0;
        repeat (6) @(negedge clk);
        spi_bits(RD, 8, rx, oa, oo);
        spi_bits(8'($urandom), 3, rx, oa, oo);
        @(negedge clk);
        check("oe_pre_rst", spi_do_oe, 1);
        spi_sck = 1;
        #2 reset_n = 0;
        #1;
        q.delete();
        m_und = 0;
        m_sent = 0;
        check("rst_async_oe", spi_do_oe, 0);
        check("rst_async_level", fifo_level, 0);
        repeat (3) @(negedge clk);
        spi_sck = 0;
        reset_n = 1;
        repeat (4) @(negedge clk);
        spi_bits(ST, 8, rx, oa, oo);
        spi_bits(8'($urandom), 8, rx, oa, oo);
        check("oe_after_rst", oo, 0);
        spi_ss = 1;
        repeat (10) @(negedge clk);
        xfer(ST, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
